burst_transfer_engine: RTL

- Parametrised successor to the fixed-size packet serializer.
- Latches a packet of up to MAX_CHUNKS chunks, DATA_WIDTH bits each, with a runtime length.
- Emits the chunks LSB-chunk-first over a valid/ready stream, each tagged with an incrementing destination address.
- Sits between the packet buffer and the downstream write port; reports completion, abort and parameter errors.

---
 rtl/burst_transfer_engine.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/burst_transfer_engine.sv
// rtl/burst_transfer_engine.sv - latches a packet and streams it out chunk by chunk with incrementing destination addresses
//
// Optional feature macro: BURST_XFER_CHECKSUM_EN (adds checksum_o, XOR of accepted chunks)
//
// Ports:
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   start_i, abort_i    transfer request (IDLE only) / cancel (XFER only)
//   src_address_i       source address, latched and echoed on src_address_o
//   dst_address_i       base destination address
//   len_i               number of chunks to send
//   data_in_i           packet, chunk k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_out_o          current chunk
//   addr_out_o          destination address of the current chunk
//   data_valid_o        beat valid; data_ready_i accepts it
//   busy_o              transfer in progress
//   done_o, error_o     one-cycle completion pulse; error_o marks a failed transfer
//   checksum_o          (optional) XOR of all accepted chunks

module burst_transfer_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CHUNKS = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = $clog2(MAX_CHUNKS) + 1
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic [ADDR_WIDTH-1:0]            src_address_i,
    input  logic [ADDR_WIDTH-1:0]            dst_address_i,
    input  logic [LEN_WIDTH-1:0]             len_i,
    input  logic [MAX_CHUNKS*DATA_WIDTH-1:0] data_in_i,
    output logic [DATA_WIDTH-1:0]            data_out_o,
    output logic [ADDR_WIDTH-1:0]            addr_out_o,
    output logic                             data_valid_o,
    input  logic                             data_ready_i,
    output logic [ADDR_WIDTH-1:0]            src_address_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             error_o
`ifdef BURST_XFER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]            checksum_o
`endif
);

    localparam int AW1 = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER   = 2'd1,
        FINISH = 2'd2,
        FAIL   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [MAX_CHUNKS*DATA_WIDTH-1:0] pkt_q;
    logic [LEN_WIDTH-1:0]             len_q;
    logic [LEN_WIDTH-1:0]             cnt_q;
    logic [ADDR_WIDTH-1:0]            addr_q;
    logic [ADDR_WIDTH-1:0]            src_q;

    logic              start_acc;
    logic              handshake;
    logic              last_beat;
    logic              bad_params;
    logic [AW1-1:0]    end_addr;

    // Highest destination address the burst would touch; the extra bit
    // catches a burst that would wrap past the top of the address space.
    assign end_addr   = {1'b0, dst_address_i} + AW1'(len_i) - AW1'(1);
    assign bad_params = (len_i == '0) ||
                        (len_i > LEN_WIDTH'(MAX_CHUNKS)) ||
                        end_addr[ADDR_WIDTH];

    assign start_acc = (state_q == IDLE) && start_i;
    // Abort wins over a same-cycle handshake, so that beat is never counted.
    assign handshake = (state_q == XFER) && data_ready_i && !abort_i;
    assign last_beat = (cnt_q == len_q - LEN_WIDTH'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = bad_params ? FAIL : XFER;
                end
            end
            XFER: begin
                if (abort_i) begin
                    state_d = FAIL;
                end else if (handshake && last_beat) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The packet is held in a shift register: the current chunk always sits
    // in the low slice, so data_out_o is a plain register tap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_q  <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            src_q  <= '0;
        end else if (start_acc) begin
            pkt_q  <= data_in_i;
            len_q  <= len_i;
            cnt_q  <= '0;
            addr_q <= dst_address_i;
            src_q  <= src_address_i;
        end else if (handshake) begin
            pkt_q  <= pkt_q >> DATA_WIDTH;
            cnt_q  <= cnt_q + LEN_WIDTH'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
        end
    end

`ifdef BURST_XFER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (handshake) begin
            csum_q <= csum_q ^ pkt_q[DATA_WIDTH-1:0];
        end
    end

    assign checksum_o = csum_q;
`endif

    assign data_out_o    = pkt_q[DATA_WIDTH-1:0];
    assign addr_out_o    = addr_q;
    assign src_address_o = src_q;
    assign data_valid_o  = (state_q == XFER);
    assign busy_o        = (state_q == XFER);
    assign done_o        = (state_q == FINISH) || (state_q == FAIL);
    assign error_o       = (state_q == FAIL);

endmodule
